// File: rtl/yd_bus_defs.sv
// +--------------------------------------------------------------------------+
// | yd_bus_defs : shared data-bus widths, master indices, lock limit default  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package yd_bus_defs;

  localparam int AW_DEF       = 16;
  localparam int DW_DEF       = 16;
  localparam int LOCK_MAX_DEF = 8;

  typedef enum logic {
    MST_CORE = 1'b0,
    MST_AUX  = 1'b1
  } mst_e;

  function automatic mst_e other_mst(input mst_e m);
    return (m == MST_CORE) ? MST_AUX : MST_CORE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_arb_pick.sv
// +--------------------------------------------------------------------------+
// | dbus_arb_pick : combinational winner selection for the two-master arbiter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dbus_arb_pick
  import yd_bus_defs::*;
(
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic       hold_vld,
  input  logic       hold_idx,
  input  logic       timeout,
  input  logic       tie_idx,
  output logic       win_vld,
  output logic       win_idx,
  output logic       win_hold
);

  logic hold_keeps;
  logic other_idx;

  assign hold_keeps = hold_vld && req[hold_idx] && lock[hold_idx] && !timeout;
  assign other_idx  = ~hold_idx;

  always_comb begin
    win_vld  = 1'b0;
    win_idx  = MST_CORE;
    win_hold = 1'b0;
    if (hold_keeps) begin
      win_vld  = 1'b1;
      win_idx  = hold_idx;
      win_hold = 1'b1;
    end else if (timeout && req[other_idx]) begin
      // A timed-out holder hands over to the waiting master, bypassing the tie rule.
      win_vld = 1'b1;
      win_idx = other_idx;
    end else if (&req) begin
      win_vld = 1'b1;
      win_idx = tie_idx;
    end else if (req[MST_CORE]) begin
      win_vld = 1'b1;
      win_idx = MST_CORE;
    end else if (req[MST_AUX]) begin
      win_vld = 1'b1;
      win_idx = MST_AUX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dbus_arb.sv
// +--------------------------------------------------------------------------+
// | dbus_arb : two-master single-beat data-bus arbiter with locked bursts.    |
// | Optional round-robin tie-break: DBUS_ARB_RR_EN.  Rev 1.0                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module dbus_arb
  import yd_bus_defs::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_lock,
  input  logic          m1_lock,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_din,
  output logic          s_we,
  input  logic [DW-1:0] s_dout
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  logic          hold_vld;
  mst_e          hold_idx;
  logic [CW-1:0] lock_cnt;
  logic          timeout;
  logic          tie_idx;
  logic          win_vld;
  logic          win_idx;
  logic          win_hold;
  logic          win_lock;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  assign timeout = hold_vld && (lock_cnt == CW'(LOCK_MAX));

`ifdef DBUS_ARB_RR_EN
  mst_e last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= MST_AUX;
    end else if (win_vld) begin
      last <= mst_e'(win_idx);
    end
  end

  assign tie_idx = other_mst(last);
`else
  assign tie_idx = MST_CORE;
`endif

  dbus_arb_pick u_pick (
    .req      ({m1_req, m0_req}),
    .lock     ({m1_lock, m0_lock}),
    .hold_vld (hold_vld),
    .hold_idx (hold_idx),
    .timeout  (timeout),
    .tie_idx  (tie_idx),
    .win_vld  (win_vld),
    .win_idx  (win_idx),
    .win_hold (win_hold)
  );

  assign m0_gnt = win_vld && (win_idx == MST_CORE);
  assign m1_gnt = win_vld && (win_idx == MST_AUX);

  assign win_lock  = (win_idx == MST_AUX) ? m1_lock  : m0_lock;
  assign win_we    = (win_idx == MST_AUX) ? m1_we    : m0_we;
  assign win_addr  = (win_idx == MST_AUX) ? m1_addr  : m0_addr;
  assign win_wdata = (win_idx == MST_AUX) ? m1_wdata : m0_wdata;

  assign s_we   = win_vld && win_we;
  assign s_addr = win_vld ? win_addr  : '0;
  assign s_din  = win_vld ? win_wdata : '0;

  // Any grant without lock, or a cycle with no grant at all, ends ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_idx <= MST_CORE;
      lock_cnt <= '0;
    end else if (win_vld && win_lock) begin
      if (win_hold) begin
        lock_cnt <= lock_cnt + CW'(1);
      end else begin
        hold_vld <= 1'b1;
        hold_idx <= mst_e'(win_idx);
        lock_cnt <= CW'(1);
      end
    end else begin
      hold_vld <= 1'b0;
      lock_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt && !m0_we;
      m1_rvalid <= m1_gnt && !m1_we;
    end
  end

  assign m0_rdata = m0_rvalid ? s_dout : '0;
  assign m1_rdata = m1_rvalid ? s_dout : '0;

endmodule

`default_nettype wire

// File: tb/tb_dbus_arb.sv
// +--------------------------------------------------------------------------+
// | tb_dbus_arb : directed self-checking bench for dbus_arb                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dbus_arb;

  localparam int AW = 16;
  localparam int DW = 16;
`ifdef DBUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;
  logic          s_we;
  logic [DW-1:0] s_dout;

  int n_cmp = 0;
  int n_bad = 0;

  dbus_arb dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_we(m0_we), .m1_we(m1_we), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_din(s_din), .s_we(s_we), .s_dout(s_dout)
  );

  always #5 clk = ~clk;

  // Slave model: read data is the presented address XOR 0xA5A5, one cycle later.
  always @(posedge clk) s_dout <= s_addr ^ 16'hA5A5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    {30'd0, m0_gnt, m1_gnt}, 32'd0);
    check({tag, "_rvalid"}, {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    check({tag, "_m0rd"},   {16'd0, m0_rdata}, 32'd0);
    check({tag, "_m1rd"},   {16'd0, m1_rdata}, 32'd0);
    check({tag, "_saddr"},  {16'd0, s_addr}, 32'd0);
    check({tag, "_sdin"},   {16'd0, s_din}, 32'd0);
    check({tag, "_swe"},    {31'd0, s_we}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");

    // m0 single read
    @(negedge clk); rst = 0; idle();
    m0_req = 1; m0_addr = 16'h0010;
    #1;
    check("rd0_gnt0", {31'd0, m0_gnt}, 32'd1);
    check("rd0_gnt1", {31'd0, m1_gnt}, 32'd0);
    check("rd0_addr", {16'd0, s_addr}, 32'h0010);
    check("rd0_we",   {31'd0, s_we}, 32'd0);

    // m1 read back-to-back with m0 return
    @(negedge clk); idle();
    m1_req = 1; m1_addr = 16'h0200;
    #1;
    check("rd0_rv0", {31'd0, m0_rvalid}, 32'd1);
    check("rd0_data", {16'd0, m0_rdata}, 32'hA5B5);
    check("rd0_rv1", {31'd0, m1_rvalid}, 32'd0);
    check("rd1_gnt1", {31'd0, m1_gnt}, 32'd1);

    @(negedge clk); idle();
    #1;
    check("rd1_rv1", {31'd0, m1_rvalid}, 32'd1);
    check("rd1_data", {16'd0, m1_rdata}, 32'hA7A5);
    check("rd1_rv0", {31'd0, m0_rvalid}, 32'd0);
    check("rd1_m0rd", {16'd0, m0_rdata}, 32'd0);

    // Tie sequence: last winner was m1, so RR alternates starting with m0
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle();
      m0_req = 1; m0_we = 1; m0_addr = 16'h0100;
      m1_req = 1; m1_we = 1; m1_addr = 16'h0300;
      #1;
      check($sformatf("tie%0d_gnt0", i), {31'd0, m0_gnt}, (RR && i[0]) ? 32'd0 : 32'd1);
      check($sformatf("tie%0d_gnt1", i), {31'd0, m1_gnt}, (RR && i[0]) ? 32'd1 : 32'd0);
      check($sformatf("tie%0d_addr", i), {16'd0, s_addr}, (RR && i[0]) ? 32'h0300 : 32'h0100);
    end

    // m1 write with m0 idle
    @(negedge clk); idle();
    m1_req = 1; m1_we = 1; m1_addr = 16'h0042; m1_wdata = 16'hBEEF;
    #1;
    check("wr_gnt1", {31'd0, m1_gnt}, 32'd1);
    check("wr_we",   {31'd0, s_we}, 32'd1);
    check("wr_addr", {16'd0, s_addr}, 32'h0042);
    check("wr_din",  {16'd0, s_din}, 32'hBEEF);
    @(negedge clk); idle();
    #1;
    check("wr_norv", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    check("idle_swe", {31'd0, s_we}, 32'd0);

    // m1 locked burst, m0 waiting from cycle 2: 8 m1 grants then forced release
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); idle();
      m1_req = 1; m1_lock = 1; m1_we = 1; m1_addr = 16'(16'h0050 + i); m1_wdata = 16'(i);
      m0_req = (i >= 2); m0_we = 1; m0_addr = 16'h0060;
      #1;
      if (i <= 9) begin
        check($sformatf("lk%0d_gnt1", i), {31'd0, m1_gnt}, (i <= 8) ? 32'd1 : 32'd0);
        check($sformatf("lk%0d_gnt0", i), {31'd0, m0_gnt}, (i == 9) ? 32'd1 : 32'd0);
      end else begin
        check("lk10_gnt1", {31'd0, m1_gnt}, RR ? 32'd1 : 32'd0);
        check("lk10_gnt0", {31'd0, m0_gnt}, RR ? 32'd0 : 32'd1);
      end
    end
    @(negedge clk); idle();
    #1 check("gap_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);

    // m0 holds for two cycles, drops lock in cycle 3 while m1 requests
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); idle();
      m0_req = 1; m0_we = 1; m0_lock = (c < 3); m0_addr = 16'h0070;
      m1_req = 1; m1_we = 1; m1_addr = 16'h0080;
      #1;
      check($sformatf("drop%0d_gnt0", c), {31'd0, m0_gnt}, (c == 3 && RR) ? 32'd0 : 32'd1);
      check($sformatf("drop%0d_gnt1", c), {31'd0, m1_gnt}, (c == 3 && RR) ? 32'd1 : 32'd0);
    end

    // Reset while a read is in flight
    @(negedge clk); idle();
    m0_req = 1; m0_lock = 1; m0_addr = 16'h0010;
    #1 check("mr_gnt_a", {31'd0, m0_gnt}, 32'd1);
    @(negedge clk);
    rst = 1;
    #1;
    check("mr_gnt_b", {31'd0, m0_gnt}, 32'd1);
    check("mr_rv_a",  {31'd0, m0_rvalid}, 32'd1);
    @(negedge clk); rst = 0; idle();
    #1 check_all_zero("post_rst");

    @(negedge clk); idle();
    m0_req = 1; m0_addr = 16'h0020;
    m1_req = 1; m1_lock = 1; m1_addr = 16'h0030;
    #1;
    check("first_tie_g0", {31'd0, m0_gnt}, 32'd1);
    check("first_tie_g1", {31'd0, m1_gnt}, 32'd0);
    @(negedge clk); idle();
    #1;
    check("first_tie_rv", {31'd0, m0_rvalid}, 32'd1);
    check("first_tie_rd", {16'd0, m0_rdata}, 32'hA585);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dbus_arb.md
# dbus_arb

Two-master arbiter that shares the single data-bus slave port (RAM + GPIO, `dbus`) between the CPU core and a second bus master such as a DMA or debug loader. It sits between the masters and `dbus` inside `SoC`. It grants at most one single-beat access per cycle, supports short locked bursts with a forced-release timeout, and routes read data back to the master that issued the read.

## Interface
- `AW`, 16, address width.
- `DW`, 16, data width.
- `LOCK_MAX`, 8, maximum consecutive granted cycles for one locked holder (≥1).

- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `m0_req`, `m1_req`  in  1  access request (m0 = core, m1 = secondary master).
- `m0_lock`, `m1_lock`  in  1  request to keep ownership for following cycles.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  AW  access address.
- `m0_wdata`, `m1_wdata`  in  DW  write data.
- `m0_gnt`, `m1_gnt`  out  1  access accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid (registered, 1 cycle after read grant).
- `m0_rdata`, `m1_rdata`  out  DW  read data; meaningful only with rvalid, otherwise 0.
- `s_addr`  out  AW  to `dbus.addr`.
- `s_din`  out  DW  to `dbus.din`.
- `s_we`  out  1  to `dbus.we`.
- `s_dout`  in  DW  from `dbus.dout`; valid the cycle after the address is presented.

## Operation
- Each cycle, winner selection:
  - If a lock holder exists, its `req`=1, and it is not timed out, the holder wins.
  - Else, if exactly one master requests, it wins.
  - Else, if both request, the tie-break winner wins (see Configuration).
  - `gnt` = 1 for the winner only; never both.
- Slave drive:
  - With a winner: `s_addr`/`s_din` come from the winner and `s_we` = winner `we`.
  - With no winner: `s_addr`=0, `s_din`=0, `s_we`=0.
- Read return: a read grant registers the owner index. Next cycle, that master's `rvalid`=1 and its `rdata`=`s_dout`. Back-to-back reads from either master are allowed.
- Lock holding:
  - A master granted with `lock`=1 becomes the holder; `lock_cnt` is set to 1.
  - Each further holder grant increments `lock_cnt`.
  - Holder releases immediately, with normal arbitration that same cycle, when it drops `req` or `lock`.
  - Timeout: when `lock_cnt`=`LOCK_MAX`, the holder is released. If the other master is requesting, it is granted in the next arbitration cycle regardless of the tie-break state.
- Tie-break pointer `last` updates to the winner index on every grant.
- Reset values:
  - All `gnt`, `rvalid`, `rdata`, `s_*` outputs = 0 (given `req` low).
  - `last` = 1, so m0 wins the first tie.
  - Holder none; `lock_cnt` = 0.
- Reset mid-operation: a pending `rvalid` is dropped, the lock is cleared, and no return is produced after reset.

## Timing
- Request to grant: 0 cycles (combinational path `req` → `gnt` → `s_*`). A transfer completes on the rising edge where `gnt`=1.
- Read latency: `rvalid` 1 cycle after the grant edge. Throughput is 1 access per cycle.
- `rdata` mux select comes from registered owner state only; there is no combinational path from `req`.
- `LOCK_MAX`=1: a lock never extends beyond one grant when the other master is waiting.

## Configuration
- `DBUS_ARB_RR_EN` defined: ties are resolved round-robin; the master not equal to `last` wins.
- Undefined: fixed priority; m0 always wins ties. Lock timeout still forces release to m1.
- The `last` register is omitted when the macro is undefined.

## Structure
- Shared package/header `yd_bus_defs`:
  - bus widths (`AW`/`DW` defaults);
  - master index constants `MST_CORE`=0 and `MST_AUX`=1;
  - default `LOCK_MAX`.
- One sub-module, `dbus_arb_pick`: combinational winner selection from `req`, holder, timeout and `last`.
- The top level holds the registers: `last`, holder, `lock_cnt`, read owner, `rvalid`.

## Test plan
- Reset, then m0 read `0x0010` alone → `m0_gnt`=1 same cycle, `s_addr`=0x0010, `s_we`=0. Next cycle `m0_rvalid`=1, `m0_rdata`=`s_dout`; `m1_rvalid`=0.
- Both request every cycle, no lock, `DBUS_ARB_RR_EN` defined → grants alternate m0, m1, m0, m1. Undefined → m0 granted every cycle.
- m1 write `0x0042` ← `0xBEEF` with m0 idle → `s_we`=1, `s_addr`=0x0042, `s_din`=0xBEEF for one cycle; no `rvalid`.
- m1 locked writes with `LOCK_MAX`=8 and m0 requesting continuously → m1 granted 8 consecutive cycles, then m0 granted on the 9th.
- Holder m0 drops `lock` in cycle 3 while m1 requests → m1 granted in cycle 3 under RR.
- m0 read granted, `rst` asserted on the next edge → no `m0_rvalid`. All outputs 0 after reset. First tie after reset goes to m0.
